mem_port_arbiter: RTL and testbench

- Owns a small DEPTH x WIDTH register-file memory and shares its single access port between two requesters (port 0, port 1).
- Each cycle it accepts at most one request, chosen round-robin. A requester can also hold a lock for back-to-back bursts.
- Writes are bit-masked. Reads return data one cycle after acceptance.
- Sits between two client engines and the shared storage array. It replaces direct single-writer memory blocks.

---
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port round-robin arbiter with lockable bursts
// in front of a bit-masked register-file memory.
module mem_port_arbiter #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [WIDTH-1:0]  req0_wdata,
    input  logic [WIDTH-1:0]  req0_mask,
    input  logic              req0_lock,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [WIDTH-1:0]  req1_wdata,
    input  logic [WIDTH-1:0]  req1_mask,
    input  logic              req1_lock,
    output logic              rsp0_valid,
    output logic              rsp1_valid,
    output logic [WIDTH-1:0]  rsp_rdata,
    output logic [1:0]        owner
);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCK0    = 2'd1,
        LOCK1    = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    state_t state, state_next;
    logic   ptr, ptr_next;     // 0 = port 0 wins a tie, 1 = port 1 wins

    logic [WIDTH-1:0] mem [DEPTH];

    logic              grant0, grant1, accept;
    logic              s_we, s_lock, in_range;
    logic [ADDR_W-1:0] s_addr;
    logic [WIDTH-1:0]  s_wdata, s_mask, rd_word;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        unique case (state)
            LOCK0: grant0 = req0_valid;
            LOCK1: grant1 = req1_valid;
            default: begin
                if (req0_valid && req1_valid) begin
                    grant0 = ~ptr;
                    grant1 = ptr;
                end else begin
                    grant0 = req0_valid;
                    grant1 = req1_valid;
                end
            end
        endcase
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign accept     = grant0 | grant1;

    always_comb begin
        s_we    = grant1 ? req1_we    : req0_we;
        s_lock  = grant1 ? req1_lock  : req0_lock;
        s_addr  = grant1 ? req1_addr  : req0_addr;
        s_wdata = grant1 ? req1_wdata : req0_wdata;
        s_mask  = grant1 ? req1_mask  : req0_mask;
    end

    assign in_range = {1'b0, s_addr} < DEPTH_L;

    // Decoded read avoids indexing past DEPTH when it is not a power of two.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (s_addr == ADDR_W'(i)) rd_word = mem[i];
        end
    end

    // Lock transitions and pointer; the pointer only stays put while a
    // locked owner keeps extending its burst.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        if (accept) begin
            if (s_lock) state_next = grant1 ? LOCK1 : LOCK0;
            else        state_next = UNLOCKED;
            if (state == UNLOCKED || !s_lock) ptr_next = ~grant1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= UNLOCKED;
            ptr   <= 1'b0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (accept && s_we && in_range && s_addr == ADDR_W'(i)) begin
                    mem[i] <= (mem[i] & ~s_mask) | (s_wdata & s_mask);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp_rdata  <= '0;
        end else begin
            rsp0_valid <= grant0 & ~req0_we;
            rsp1_valid <= grant1 & ~req1_we;
            if (accept && !s_we) rsp_rdata <= in_range ? rd_word : '0;
        end
    end

    always_comb begin
        unique case (state)
            LOCK0:   owner = 2'b01;
            LOCK1:   owner = 2'b10;
            default: owner = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - table-driven bench for mem_port_arbiter.
module tb_mem_port_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready, req0_we, req0_lock;
    logic [1:0] req0_addr;
    logic [7:0] req0_wdata, req0_mask;
    logic       req1_valid, req1_ready, req1_we, req1_lock;
    logic [1:0] req1_addr;
    logic [7:0] req1_wdata, req1_mask;
    logic       rsp0_valid, rsp1_valid;
    logic [7:0] rsp_rdata;
    logic [1:0] owner;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_mask(req0_mask),
        .req0_lock(req0_lock),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_mask(req1_mask),
        .req1_lock(req1_lock),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_rdata(rsp_rdata),
        .owner(owner)
    );

    typedef struct {
        logic       v0, w0, l0;
        logic [1:0] a0;
        logic [7:0] d0, m0;
        logic       v1, w1, l1;
        logic [1:0] a1;
        logic [7:0] d1, m1;
        logic       er0, er1, ev0, ev1;
        logic [7:0] ed;
        logic [1:0] eo;
    } vec_t;

    vec_t tbl[$];
    vec_t post[$];

    function automatic vec_t mk(
        logic v0, logic w0, logic l0, logic [1:0] a0, logic [7:0] d0, logic [7:0] m0,
        logic v1, logic w1, logic l1, logic [1:0] a1, logic [7:0] d1, logic [7:0] m1,
        logic er0, logic er1, logic ev0, logic ev1, logic [7:0] ed, logic [1:0] eo);
        vec_t v;
        v.v0 = v0; v.w0 = w0; v.l0 = l0; v.a0 = a0; v.d0 = d0; v.m0 = m0;
        v.v1 = v1; v.w1 = w1; v.l1 = l1; v.a1 = a1; v.d1 = d1; v.m1 = m1;
        v.er0 = er0; v.er1 = er1; v.ev0 = ev0; v.ev1 = ev1; v.ed = ed; v.eo = eo;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d actual=%0h expected=%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        req0_valid = v.v0; req0_we = v.w0; req0_lock = v.l0;
        req0_addr = v.a0; req0_wdata = v.d0; req0_mask = v.m0;
        req1_valid = v.v1; req1_we = v.w1; req1_lock = v.l1;
        req1_addr = v.a1; req1_wdata = v.d1; req1_mask = v.m1;
    endtask

    task automatic idle();
        drive(mk(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 2'b00));
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic apply(input vec_t v, input int idx);
        drive(v);
        #2;
        chk("req0_ready", idx, 32'(req0_ready), 32'(v.er0));
        chk("req1_ready", idx, 32'(req1_ready), 32'(v.er1));
        @(posedge clk);
        #1;
        chk("rsp0_valid", idx, 32'(rsp0_valid), 32'(v.ev0));
        chk("rsp1_valid", idx, 32'(rsp1_valid), 32'(v.ev1));
        chk("rsp_rdata", idx, 32'(rsp_rdata), 32'(v.ed));
        chk("owner", idx, 32'(owner), 32'(v.eo));
    endtask

    initial begin
        //            p0: v w l a  wdata  mask    p1: v w l a  wdata  mask    er0 er1 ev0 ev1 rdata  owner
        // reads after reset, alternating ports
        tbl.push_back(mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 1, 0, 8'h00, 2'b00));
        tbl.push_back(mk(0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 1, 8'h00, 8'h00, 0, 1, 0, 1, 8'h00, 2'b00));
        tbl.push_back(mk(1, 0, 0, 2, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 1, 0, 8'h00, 2'b00));
        tbl.push_back(mk(0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 3, 8'h00, 8'h00, 0, 1, 0, 1, 8'h00, 2'b00));
        // both valid, round-robin 0,1,0,1
        tbl.push_back(mk(1, 1, 0, 1, 8'hA5, 8'hFF, 1, 1, 0, 2, 8'h3C, 8'hFF, 1, 0, 0, 0, 8'h00, 2'b00));
        tbl.push_back(mk(1, 1, 0, 1, 8'hA5, 8'hFF, 1, 1, 0, 2, 8'h3C, 8'hFF, 0, 1, 0, 0, 8'h00, 2'b00));
        tbl.push_back(mk(1, 1, 0, 1, 8'hA5, 8'hFF, 1, 1, 0, 2, 8'h3C, 8'hFF, 1, 0, 0, 0, 8'h00, 2'b00));
        tbl.push_back(mk(1, 1, 0, 1, 8'hA5, 8'hFF, 1, 1, 0, 2, 8'h3C, 8'hFF, 0, 1, 0, 0, 8'h00, 2'b00));
        tbl.push_back(mk(1, 0, 0, 1, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 1, 0, 8'hA5, 2'b00));
        tbl.push_back(mk(0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 2, 8'h00, 8'h00, 0, 1, 0, 1, 8'h3C, 2'b00));
        tbl.push_back(mk(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h3C, 2'b00));
        // masked writes
        tbl.push_back(mk(1, 1, 0, 3, 8'hFF, 8'hFF, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 8'h3C, 2'b00));
        tbl.push_back(mk(0, 0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 3, 8'h00, 8'h0F, 0, 1, 0, 0, 8'h3C, 2'b00));
        tbl.push_back(mk(1, 0, 0, 3, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 1, 0, 8'hF0, 2'b00));
        tbl.push_back(mk(0, 0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 3, 8'h00, 8'h00, 0, 1, 0, 0, 8'hF0, 2'b00));
        tbl.push_back(mk(0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 3, 8'h00, 8'h00, 0, 1, 0, 1, 8'hF0, 2'b00));
        // pointer to port 1, then port 1 lock burst with port 0 always valid
        tbl.push_back(mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 1, 0, 8'h00, 2'b00));
        tbl.push_back(mk(1, 0, 0, 1, 8'h00, 8'h00, 1, 1, 1, 0, 8'h11, 8'hFF, 0, 1, 0, 0, 8'h00, 2'b10));
        tbl.push_back(mk(1, 0, 0, 1, 8'h00, 8'h00, 1, 0, 1, 0, 8'h00, 8'h00, 0, 1, 0, 1, 8'h11, 2'b10));
        tbl.push_back(mk(1, 0, 0, 1, 8'h00, 8'h00, 1, 1, 1, 0, 8'h22, 8'hF0, 0, 1, 0, 0, 8'h11, 2'b10));
        tbl.push_back(mk(1, 0, 0, 1, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 1, 8'h21, 2'b00));
        tbl.push_back(mk(1, 0, 0, 1, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00, 1, 0, 1, 0, 8'hA5, 2'b00));
        // port 0 lock held across idle and against a valid port 1
        tbl.push_back(mk(1, 0, 1, 2, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 1, 0, 8'h3C, 2'b01));
        tbl.push_back(mk(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h3C, 2'b01));
        tbl.push_back(mk(0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 1, 8'h00, 8'h00, 0, 0, 0, 0, 8'h3C, 2'b01));
        tbl.push_back(mk(1, 0, 0, 3, 8'h00, 8'h00, 1, 0, 0, 1, 8'h00, 8'h00, 1, 0, 1, 0, 8'hF0, 2'b00));
        tbl.push_back(mk(0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 1, 8'h00, 8'h00, 0, 1, 0, 1, 8'hA5, 2'b00));
        // read-after-write across ports
        tbl.push_back(mk(1, 1, 0, 2, 8'h77, 8'hFF, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 8'hA5, 2'b00));
        tbl.push_back(mk(0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 2, 8'h00, 8'h00, 0, 1, 0, 1, 8'h77, 2'b00));

        // after mid-burst reset: tie goes to port 0, memory reads back zero
        post.push_back(mk(1, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 1, 8'h00, 8'h00, 1, 0, 1, 0, 8'h00, 2'b00));
        post.push_back(mk(1, 0, 0, 2, 8'h00, 8'h00, 1, 0, 0, 3, 8'h00, 8'h00, 0, 1, 0, 1, 8'h00, 2'b00));
        post.push_back(mk(1, 0, 0, 1, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 1, 0, 8'h00, 2'b00));
        post.push_back(mk(0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 2, 8'h00, 8'h00, 0, 1, 0, 1, 8'h00, 2'b00));

        rst = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("reset rsp0_valid", -1, 32'(rsp0_valid), 32'd0);
        chk("reset rsp1_valid", -1, 32'(rsp1_valid), 32'd0);
        chk("reset rsp_rdata", -1, 32'(rsp_rdata), 32'd0);
        chk("reset owner", -1, 32'(owner), 32'd0);
        rst = 1'b1;

        foreach (tbl[i]) apply(tbl[i], i);

        // lock port 0 with a read so a response is valid, then reset
        apply(mk(1, 0, 1, 2, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 1, 0, 8'h77, 2'b01), 100);
        idle();
        rst = 1'b0;
        #1;
        chk("midrst owner", 101, 32'(owner), 32'd0);
        chk("midrst rsp0_valid", 101, 32'(rsp0_valid), 32'd0);
        chk("midrst rsp_rdata", 101, 32'(rsp_rdata), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        foreach (post[i]) apply(post[i], 200 + i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
